bomb_ctrl: RTL and testbench
============================

# bomb_ctrl

Sequencer for the single bomb resource drawn by the VGA renderer. It accepts a place request and latches the player's tile, then runs the fuse countdown and the explosion window. It drives `Bomb_EN`, `Boom`, `Bomb_x/y` and the per-direction `Fire` blocking mask to the display, and reports player and monster hits to game logic. It sits between the input/game-state logic and the VGA block.

## Interface
- `FUSE_TICKS`, default 3: number of `tick` pulses the bomb stays armed.
- `BOOM_TICKS`, default 2: number of `tick` pulses the explosion stays visible.
- `CNT_W`, default 4: width of the tick counter; must satisfy `2^CNT_W > max(FUSE_TICKS, BOOM_TICKS)`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `tick`, input, 1: one-cycle time-base enable, e.g. 1 Hz from the clock divider.
- `place_req`, input, 1: player request to place a bomb; level or pulse.
- `freeze`, input, 1: game over (`win|lose`); blocks new placements.
- `Man_x`, `Man_y`, input, 5 each: player tile in map coordinates, x 0..15, y 0..14.
- `Monster_alive`, input, 1: monster present.
- `Monster_x`, `Monster_y`, input, 5 each: monster tile.
- `Bomb_EN`, output, 1: bomb visible and armed.
- `Boom`, output, 1: explosion visible.
- `Bomb_x`, `Bomb_y`, output, 5 each: latched bomb tile.
- `Fire`, output, 4: per-arm blocked flags. Bit 0 = left, 1 = up, 2 = right, 3 = down. 1 means the arm is blocked by a wall.
- `man_hit`, output, 1: one-cycle pulse; player caught in the blast.
- `monster_hit`, output, 1: one-cycle pulse; monster caught in the blast.

## Operation
- **Wall rule**, combinational on any tile (x, y). A tile is a wall if x==0, x==15, y==0 or y==14, or if x ∈ {2,4,6,9,11,13} and y is even.
- **FSM states:** IDLE, ARMED, BOOM.
- **IDLE → ARMED:** when `place_req`=1 and `freeze`=0.
  - Latch `Bomb_x/y` ← `Man_x/y`.
  - Latch `Fire` ← wall flags of (x-1,y), (x,y-1), (x+1,y), (x,y+1).
  - Clear the counter.
- **ARMED:** the counter increments on each `tick`.
  - On the tick where counter == `FUSE_TICKS`-1: go to BOOM and clear the counter.
  - `place_req` is ignored in ARMED; there is one bomb only.
- **BOOM:** the counter increments on each `tick`.
  - On the tick where counter == `BOOM_TICKS`-1: go to IDLE.
  - Blast cells are the centre plus each arm whose `Fire` bit is 0.
- **Hit detection:** evaluated every cycle in BOOM.
  - `man_hit` pulses on the first cycle the player is in a blast cell; a sticky flag suppresses repeats within the same explosion.
  - `monster_hit` works the same way and additionally requires `Monster_alive`=1.
  - Both sticky flags clear on entry to ARMED.
- **Freeze:** `freeze` does not abort a bomb already armed; it only blocks new placements.
- **Outputs:** `Bomb_EN` = (state==ARMED) and `Boom` = (state==BOOM), both registered.
- **Hold behaviour:** `Bomb_x/y` and `Fire` hold their last values in IDLE.
- **Arithmetic:** neighbour coordinates are 5-bit wraparound. Edge underflow cannot occur because the bomb tile is never on the border, so its neighbours are always valid.

## Timing
- **Reset values:** state=IDLE, counter=0, `Bomb_EN`=0, `Boom`=0, `Bomb_x`=0, `Bomb_y`=0, `Fire`=4'b0000, `man_hit`=0, `monster_hit`=0, sticky flags=0.
- **Reset mid-operation:** `rst` during ARMED or BOOM returns to the reset values on the next edge.
- **Placement latency:** `place_req` sampled high at edge N (state IDLE) gives `Bomb_EN`=1 and valid `Bomb_x/y`/`Fire` after edge N.
- **Fuse timing:** `Boom` rises after the edge that samples the `FUSE_TICKS`-th `tick`. `Bomb_EN` falls at that same edge; there is no overlap and no gap.
- **Explosion timing:** `Boom` falls after the edge that samples the `BOOM_TICKS`-th `tick`.
- **Re-placement:** a `place_req` held high re-places on the first cycle back in IDLE, i.e. one cycle after `Boom` falls.
- **Tick on the placement cycle:** a `tick` coincident with the IDLE→ARMED transition is not counted.
- **Hit latency:** hit pulses are registered, so they appear one cycle after the qualifying state/position, at most once per explosion.
- **Simultaneous hits:** `man_hit` and `monster_hit` may pulse in the same cycle.

## Test plan
- **Normal cycle:** reset, Man=(1,1), `place_req` pulse, FUSE=3, BOOM=2.
  - Expect `Bomb_EN`=1, Bomb=(1,1), `Fire`=4'b0011 (left x=0 wall, up y=0 wall; right (2,1) open; down (1,2) open).
  - After the 3rd tick: `Boom`=1 and `Bomb_EN`=0.
  - After the 5th tick: `Boom`=0.
- **Blocked arms / man hit:** bomb at (3,2).
  - Expect `Fire`=4'b0101 ((2,2) and (4,2) are walls; (3,1) and (3,3) open).
  - Man at (3,3) during BOOM: exactly one `man_hit` pulse even if he stays there.
- **Monster hit:** monster at (2,1), bomb at (1,1).
  - With `Monster_alive`=1: one `monster_hit` pulse.
  - Repeated with `Monster_alive`=0: no pulse.
  - Monster at (0,1) (blocked arm): no pulse.
- **Ignored / frozen requests:**
  - `place_req` held high in ARMED: Bomb_x/y unchanged when Man moves.
  - `freeze`=1 in IDLE with `place_req`: stays IDLE, `Bomb_EN`=0.
- **Reset mid-operation:** `rst` asserted mid-BOOM.
  - Next cycle: all outputs at reset values.
  - A following `place_req` arms normally.
- **Tick on placement edge:** `tick` asserted on the same cycle as the accepted `place_req`; `Boom` still requires 3 further ticks.

Source files
------------

// File: rtl/bomb_ctrl_if.sv
// rtl/bomb_ctrl_if.sv - bomb sequencer bundle between game logic, bomb_ctrl and the VGA renderer.
interface bomb_ctrl_if;
  logic       tick;
  logic       place_req;
  logic       freeze;
  logic [4:0] Man_x;
  logic [4:0] Man_y;
  logic       Monster_alive;
  logic [4:0] Monster_x;
  logic [4:0] Monster_y;
  logic       Bomb_EN;
  logic       Boom;
  logic [4:0] Bomb_x;
  logic [4:0] Bomb_y;
  logic [3:0] Fire;
  logic       man_hit;
  logic       monster_hit;

  modport master (
    output tick, place_req, freeze, Man_x, Man_y, Monster_alive, Monster_x, Monster_y,
    input  Bomb_EN, Boom, Bomb_x, Bomb_y, Fire, man_hit, monster_hit
  );

  modport slave (
    input  tick, place_req, freeze, Man_x, Man_y, Monster_alive, Monster_x, Monster_y,
    output Bomb_EN, Boom, Bomb_x, Bomb_y, Fire, man_hit, monster_hit
  );
endinterface

// File: rtl/bomb_ctrl.sv
// rtl/bomb_ctrl.sv - single-bomb sequencer: placement, fuse countdown, explosion window, hit pulses.
module bomb_ctrl #(
  parameter int FUSE_TICKS = 3,
  parameter int BOOM_TICKS = 2,
  parameter int CNT_W      = 4
) (
  input logic         clk,
  input logic         rst,
  bomb_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BOOM} state_e;

  localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_TICKS - 1);
  localparam logic [CNT_W-1:0] BOOM_LAST = CNT_W'(BOOM_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bx_q, bx_d, by_q, by_d;
  logic [3:0]       fire_q, fire_d;
  logic             man_hit_q, man_hit_d, mon_hit_q, mon_hit_d;
  logic             man_seen_q, man_seen_d, mon_seen_q, mon_seen_d;
  logic             man_in_blast, mon_in_blast;

  function automatic logic is_wall(input logic [4:0] x, input logic [4:0] y);
    logic pillar_col;
    pillar_col = (x == 5'd2) || (x == 5'd4) || (x == 5'd6) ||
                 (x == 5'd9) || (x == 5'd11) || (x == 5'd13);
    return (x == 5'd0) || (x == 5'd15) || (y == 5'd0) || (y == 5'd14) ||
           (pillar_col && !y[0]);
  endfunction

  // Centre always burns; each arm burns only when its Fire bit marks it open.
  function automatic logic in_blast(input logic [4:0] px, input logic [4:0] py,
                                    input logic [4:0] cx, input logic [4:0] cy,
                                    input logic [3:0] blk);
    return ((px == cx)         && (py == cy))                      ||
           ((px == cx - 5'd1)  && (py == cy)         && !blk[0])   ||
           ((px == cx)         && (py == cy - 5'd1)  && !blk[1])   ||
           ((px == cx + 5'd1)  && (py == cy)         && !blk[2])   ||
           ((px == cx)         && (py == cy + 5'd1)  && !blk[3]);
  endfunction

  assign man_in_blast = in_blast(bus.Man_x, bus.Man_y, bx_q, by_q, fire_q);
  assign mon_in_blast = bus.Monster_alive &&
                        in_blast(bus.Monster_x, bus.Monster_y, bx_q, by_q, fire_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bx_d       = bx_q;
    by_d       = by_q;
    fire_d     = fire_q;
    man_hit_d  = 1'b0;
    mon_hit_d  = 1'b0;
    man_seen_d = man_seen_q;
    mon_seen_d = mon_seen_q;
    case (state_q)
      S_IDLE: begin
        if (bus.place_req && !bus.freeze) begin
          state_d    = S_ARMED;
          cnt_d      = '0;
          bx_d       = bus.Man_x;
          by_d       = bus.Man_y;
          fire_d     = {is_wall(bus.Man_x, bus.Man_y + 5'd1),
                        is_wall(bus.Man_x + 5'd1, bus.Man_y),
                        is_wall(bus.Man_x, bus.Man_y - 5'd1),
                        is_wall(bus.Man_x - 5'd1, bus.Man_y)};
          man_seen_d = 1'b0;
          mon_seen_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (bus.tick) begin
          if (cnt_q == FUSE_LAST) begin
            state_d = S_BOOM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_BOOM: begin
        if (man_in_blast && !man_seen_q) begin
          man_hit_d  = 1'b1;
          man_seen_d = 1'b1;
        end
        if (mon_in_blast && !mon_seen_q) begin
          mon_hit_d  = 1'b1;
          mon_seen_d = 1'b1;
        end
        if (bus.tick) begin
          if (cnt_q == BOOM_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      fire_q     <= '0;
      man_hit_q  <= 1'b0;
      mon_hit_q  <= 1'b0;
      man_seen_q <= 1'b0;
      mon_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      fire_q     <= fire_d;
      man_hit_q  <= man_hit_d;
      mon_hit_q  <= mon_hit_d;
      man_seen_q <= man_seen_d;
      mon_seen_q <= mon_seen_d;
    end
  end

  assign bus.Bomb_EN     = (state_q == S_ARMED);
  assign bus.Boom        = (state_q == S_BOOM);
  assign bus.Bomb_x      = bx_q;
  assign bus.Bomb_y      = by_q;
  assign bus.Fire        = fire_q;
  assign bus.man_hit     = man_hit_q;
  assign bus.monster_hit = mon_hit_q;

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb/tb_bomb_ctrl.sv - directed scoreboard bench for bomb_ctrl.
module tb_bomb_ctrl;

  typedef struct {
    string      tag;
    logic       en;
    logic       boom;
    logic [4:0] x;
    logic [4:0] y;
    logic [3:0] fire;
    logic       mh;
    logic       mo;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  logic [4:0] exp_bx, exp_by;
  logic [3:0] exp_fire;

  bomb_ctrl_if bus();

  bomb_ctrl #(.FUSE_TICKS(3), .BOOM_TICKS(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic t, input logic p,
                      input logic en, input logic bm, input logic mh, input logic mo);
    exp_t e;
    exp_t got;
    bus.tick      = t;
    bus.place_req = p;
    e.tag  = tag;
    e.en   = en;
    e.boom = bm;
    e.x    = exp_bx;
    e.y    = exp_by;
    e.fire = exp_fire;
    e.mh   = mh;
    e.mo   = mo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({got.tag, ".Bomb_EN"},     8'(bus.Bomb_EN),     8'(got.en));
    chk({got.tag, ".Boom"},        8'(bus.Boom),        8'(got.boom));
    chk({got.tag, ".Bomb_x"},      8'(bus.Bomb_x),      8'(got.x));
    chk({got.tag, ".Bomb_y"},      8'(bus.Bomb_y),      8'(got.y));
    chk({got.tag, ".Fire"},        8'(bus.Fire),        8'(got.fire));
    chk({got.tag, ".man_hit"},     8'(bus.man_hit),     8'(got.mh));
    chk({got.tag, ".monster_hit"}, 8'(bus.monster_hit), 8'(got.mo));
  endtask

  // Full place -> fuse -> explosion -> idle sequence with player/monster moved after placement.
  task automatic run_bomb(input string tag, input logic [4:0] px, input logic [4:0] py,
                          input logic [3:0] fire, input logic [4:0] mx, input logic [4:0] my,
                          input logic [4:0] ox, input logic [4:0] oy, input logic alive,
                          input logic mh, input logic mo, input logic tick_on_place);
    bus.Man_x = px;
    bus.Man_y = py;
    exp_bx    = px;
    exp_by    = py;
    exp_fire  = fire;
    step({tag, "_place"}, tick_on_place, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.Man_x         = mx;
    bus.Man_y         = my;
    bus.Monster_x     = ox;
    bus.Monster_y     = oy;
    bus.Monster_alive = alive;
    step({tag, "_t1"},   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step({tag, "_t2"},   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step({tag, "_t3"},   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step({tag, "_hit"},  1'b0, 1'b0, 1'b0, 1'b1, mh,   mo);
    step({tag, "_hold"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step({tag, "_b1"},   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step({tag, "_b2"},   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst               = 1'b1;
    bus.tick          = 1'b0;
    bus.place_req     = 1'b0;
    bus.freeze        = 1'b0;
    bus.Man_x         = 5'd1;
    bus.Man_y         = 5'd1;
    bus.Monster_alive = 1'b0;
    bus.Monster_x     = 5'd9;
    bus.Monster_y     = 5'd9;
    exp_bx            = 5'd0;
    exp_by            = 5'd0;
    exp_fire          = 4'b0000;

    step("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    run_bomb("normal",   5'd1, 5'd1, 4'b0011, 5'd5, 5'd5, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    run_bomb("blocked",  5'd3, 5'd2, 4'b0101, 5'd3, 5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    run_bomb("both_hit", 5'd1, 5'd1, 4'b0011, 5'd1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_bomb("mon_dead", 5'd1, 5'd1, 4'b0011, 5'd5, 5'd5, 5'd2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_bomb("mon_wall", 5'd1, 5'd1, 4'b0011, 5'd5, 5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_bomb("place_tk", 5'd3, 5'd2, 4'b0101, 5'd3, 5'd1, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);

    // place_req held through a whole bomb: ignored while busy, re-places on first idle cycle
    bus.Monster_alive = 1'b0;
    bus.Man_x = 5'd1;
    bus.Man_y = 5'd1;
    exp_bx    = 5'd1;
    exp_by    = 5'd1;
    exp_fire  = 4'b0011;
    step("held_place", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.Man_x = 5'd3;
    bus.Man_y = 5'd2;
    step("held_t1",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("held_t2",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("held_t3",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("held_b1",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("held_b2",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_bx   = 5'd3;
    exp_by   = 5'd2;
    exp_fire = 4'b0101;
    step("replace",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("re_t1",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("re_t2",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("re_t3",     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("re_hit",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    rst      = 1'b1;
    exp_bx   = 5'd0;
    exp_by   = 5'd0;
    exp_fire = 4'b0000;
    step("mid_rst",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    bus.freeze = 1'b1;
    bus.Man_x  = 5'd1;
    bus.Man_y  = 5'd1;
    step("freeze1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("freeze2",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.freeze = 1'b0;

    run_bomb("post_rst", 5'd1, 5'd1, 4'b0011, 5'd5, 5'd5, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
